uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver, 8N1, LSB first; receive-side counterpart of the team's UART transmitter.
//   Synchronises the asynchronous serial line, detects the start bit and samples each bit at mid-bit.
//   Delivers each valid byte with a one-cycle strobe, and flags framing errors and line breaks.
//   Sits between the external RX pin and the byte-level consumer logic.
// PARAMETERS
//   CLKS_PER_BIT  87  i_clk cycles per UART bit; legal range 4..255 (8-bit bit-timer).
// PORTS
//   i_clk        in   1  system clock; all logic on the rising edge
//   i_rst        in   1  reset; asynchronous, active-high
//   i_rx_serial  in   1  serial line, asynchronous to i_clk, idles high
//   o_rx_byte    out  8  last correctly framed byte; updated only together with o_rx_dv
//   o_rx_dv      out  1  one-cycle pulse: o_rx_byte holds a new valid byte
//   o_rx_active  out  1  high while a frame is in progress (START..STOP)
//   o_frame_err  out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - outputs: o_rx_byte=0, o_rx_dv=0, o_rx_active=0, o_frame_err=0
//     - internal: synchroniser flops=1, state=IDLE, counters=0
//   Synchroniser: 2-FF on i_rx_serial; all decisions use the 2nd-stage output rx_s.
//   HALF = (CLKS_PER_BIT-1)/2 (integer division).
//   State machine, 3-bit encoded:
//     - IDLE: clk_cnt=0, bit_idx=0. rx_s==0 -> START, o_rx_active=1.
//     - START: count to HALF. rx_s still 0 -> DATA, clk_cnt=0.
//       rx_s==1 -> glitch; back to IDLE, o_rx_active=0, no other output changes.
//     - DATA: count CLKS_PER_BIT-1 clocks, then sample rx_s into shift[bit_idx], bit_idx++.
//       After bit 7 -> STOP, clk_cnt=0. bit_idx is 3 bits and resets to 0 on exit.
//     - STOP: count CLKS_PER_BIT-1 clocks, then sample.
//       rx_s==1 -> o_rx_byte<=shift and o_rx_dv=1 (same edge).
//       rx_s==0 -> o_frame_err=1; o_rx_byte unchanged.
//       Either way -> CLEANUP, o_rx_active=0.
//     - CLEANUP: o_rx_dv/o_frame_err return to 0 (pulse width exactly 1 cycle).
//       Exit to IDLE only when rx_s==1; a held-low line (break) waits here.
//       A break gives exactly one o_frame_err, never a spurious start.
//     - Illegal encodings -> IDLE.
//   Timing:
//     - sample point for bit n is (n+1)*CLKS_PER_BIT + HALF clocks after start detection.
//     - o_rx_dv rises at 9*CLKS_PER_BIT + HALF + 3 (+/-1) clocks after the input falling edge.
//   Back-to-back frames: a start bit that begins right after the stop bit is accepted.
//     CLEANUP lasts 1 cycle when the line is high, so there is no minimum idle gap.
//   o_rx_dv and o_frame_err are mutually exclusive and never high in consecutive cycles.
//   Reset mid-frame: the partial byte is discarded; o_rx_byte=0.
//     The next complete frame after release is received normally.
//   No flow control: the consumer must take o_rx_byte before the next o_rx_dv.
//     That window is at least ~10 bit times.
// TESTING (CLKS_PER_BIT=8 unless noted; bench drives ideal 8-clk bits)
//   1. Frame 0xA5, stop=1 -> single 1-cycle o_rx_dv, o_rx_byte=0xA5, o_frame_err never high.
//   2. Low glitch of 3 clks, then line high -> no o_rx_dv/o_frame_err; o_rx_active high <=6 clks, then 0.
//   3. Frame 0x3C with stop=0 after a good 0xA5 -> one o_frame_err pulse, no o_rx_dv, o_rx_byte stays 0xA5.
//   4. 0x00 then 0xFF back-to-back, no idle gap -> two o_rx_dv pulses, 80+/-1 clks apart, bytes 0x00 then 0xFF.
//   5. Assert i_rst during bit 4 of 0x5A -> all outputs 0 immediately; next frame 0x5A gives o_rx_byte=0x5A.
//   6. Line low for 20 bit times, then high, then 0x81 -> exactly one o_frame_err, no o_rx_dv until 0x81 arrives.
//   7. CLKS_PER_BIT=87, frame 0x96 -> o_rx_byte=0x96, o_rx_dv at 9*87+43+3 (+/-1) clks after the falling edge.

Source files
------------

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver, LSB first, with a 2-FF synchroniser, mid-bit sampling and framing-error/break detection.
// Latency: o_rx_dv rises 9*CLKS_PER_BIT + HALF + 3 (+/-1) clocks after the start-bit falling edge.
// Backpressure: none; the consumer must take o_rx_byte before the next o_rx_dv, at least ~10 bit times later.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87  // legal range 4..255, the bit timer is 8 bits wide
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_rx_active,
  output logic       o_frame_err
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  logic       rx_meta;
  logic       rx_s;
  state_t     state, state_n;
  logic [7:0] clk_cnt, clk_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] rx_byte_n;
  logic       rx_dv_n;
  logic       rx_active_n;
  logic       frame_err_n;

  // Two-stage synchroniser; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      clk_cnt     <= 8'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      o_rx_byte   <= 8'd0;
      o_rx_dv     <= 1'b0;
      o_rx_active <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_rx_byte   <= rx_byte_n;
      o_rx_dv     <= rx_dv_n;
      o_rx_active <= rx_active_n;
      o_frame_err <= frame_err_n;
    end
  end

  // Next-state and output logic; strobes default low so each pulse lasts exactly one cycle.
  always_comb begin
    state_n     = state;
    clk_cnt_n   = clk_cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    rx_byte_n   = o_rx_byte;
    rx_dv_n     = 1'b0;
    frame_err_n = 1'b0;
    rx_active_n = o_rx_active;

    case (state)
      IDLE: begin
        clk_cnt_n = 8'd0;
        bit_idx_n = 3'd0;
        if (!rx_s) begin
          state_n     = START;
          rx_active_n = 1'b1;
        end
      end

      START: begin
        // Re-check the line half a bit in; a short low pulse is treated as a glitch.
        if (clk_cnt == HALF) begin
          clk_cnt_n = 8'd0;
          if (!rx_s) begin
            state_n = DATA;
          end else begin
            state_n     = IDLE;
            rx_active_n = 1'b0;
          end
        end else begin
          clk_cnt_n = clk_cnt + 8'd1;
        end
      end

      DATA: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n        = 8'd0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_n = 3'd0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 8'd1;
        end
      end

      STOP: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n   = 8'd0;
          state_n     = CLEANUP;
          rx_active_n = 1'b0;
          if (rx_s) begin
            rx_byte_n = shift;
            rx_dv_n   = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 8'd1;
        end
      end

      CLEANUP: begin
        // A held-low line (break) parks here so it cannot be mistaken for a new start bit.
        clk_cnt_n = 8'd0;
        bit_idx_n = 3'd0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n     = IDLE;
        clk_cnt_n   = 8'd0;
        bit_idx_n   = 3'd0;
        rx_active_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed bench for uart_rx at 8 and 87 clocks per bit.
// Latency: checks o_rx_dv timing relative to the start-bit falling edge.
// Backpressure: not applicable; the bench only drives the serial lines.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx87 = 1'b1;

  logic [7:0] byte8, byte87;
  logic       dv8, dv87, act8, act87, ferr8, ferr87;

  uart_rx #(.CLKS_PER_BIT(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx8),
    .o_rx_byte(byte8), .o_rx_dv(dv8), .o_rx_active(act8), .o_frame_err(ferr8)
  );

  uart_rx #(.CLKS_PER_BIT(87)) dut87 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx87),
    .o_rx_byte(byte87), .o_rx_dv(dv87), .o_rx_active(act87), .o_frame_err(ferr87)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  // Monitor state, sampled on the falling clock edge.
  int         dv_cnt = 0;
  int         ferr_cnt = 0;
  int         act_cycles = 0;
  int         viol = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] dv_bytes[$];
  int         dv_times[$];
  int         dv87_cnt = 0;
  int         dv87_cyc = 0;
  logic [7:0] dv87_byte = 8'h00;
  int         fall_cyc = 0;

  always @(negedge clk) begin
    if (dv8) begin
      dv_cnt++;
      dv_bytes.push_back(byte8);
      dv_times.push_back(cyc);
    end
    if (ferr8) ferr_cnt++;
    if (act8) act_cycles++;
    if (dv8 && ferr8) viol++;
    if ((dv8 || ferr8) && prev_strobe) viol++;
    prev_strobe = dv8 | ferr8;
    if (dv87) begin
      dv87_cnt++;
      dv87_cyc  = cyc;
      dv87_byte = byte87;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    checks++;
    if (act < exp - 1 || act > exp + 1)
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    else
      passed++;
  endtask

  task automatic clear_mon();
    dv_cnt     = 0;
    ferr_cnt   = 0;
    act_cycles = 0;
    dv_bytes   = {};
    dv_times   = {};
  endtask

  // Drives a full 10-bit frame starting at a falling clock edge; records the start-bit fall time.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit big);
    int         cpb;
    logic [9:0] bits;
    cpb  = big ? 87 : 8;
    bits = {stop_b, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (big) rx87 = bits[i]; else rx8 = bits[i];
      if (i == 0) fall_cyc = cyc;
      repeat (cpb) @(negedge clk);
    end
    if (big) rx87 = 1'b1; else rx8 = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic [7:0] exp_byte;
    int         exp_dv;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
    vecs[2] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 1, 0};

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset byte", 32'(byte8), 32'h00);
    chk("reset dv", 32'(dv8), 32'h0);
    chk("reset active", 32'(act8), 32'h0);
    chk("reset ferr", 32'(ferr8), 32'h0);
    chk("reset byte87", 32'(byte87), 32'h00);
    rst = 1'b0;
    repeat (16) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop_b, 1'b0);
      repeat (16) @(negedge clk);
      chk($sformatf("vec%0d dv count", v), 32'(dv_cnt), 32'(vecs[v].exp_dv));
      chk($sformatf("vec%0d ferr count", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
      chk($sformatf("vec%0d byte", v), 32'(byte8), 32'(vecs[v].exp_byte));
      chk($sformatf("vec%0d active idle", v), 32'(act8), 32'h0);
      if (vecs[v].exp_dv == 1 && dv_bytes.size() == 1)
        chk($sformatf("vec%0d byte at dv", v), 32'(dv_bytes[0]), 32'(vecs[v].exp_byte));
    end

    // Three-clock low glitch
    clear_mon();
    rx8 = 1'b0;
    repeat (3) @(negedge clk);
    rx8 = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch dv", 32'(dv_cnt), 32'h0);
    chk("glitch ferr", 32'(ferr_cnt), 32'h0);
    checks++;
    if (act_cycles < 1 || act_cycles > 6)
      $display("FAIL glitch active cycles: got %0d, expected 1..6", act_cycles);
    else
      passed++;
    chk("glitch active end", 32'(act8), 32'h0);

    // Back-to-back frames with no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    chk("b2b dv count", 32'(dv_cnt), 32'd2);
    if (dv_cnt == 2) begin
      chk("b2b first byte", 32'(dv_bytes[0]), 32'h00);
      chk("b2b second byte", 32'(dv_bytes[1]), 32'hFF);
      chk_near("b2b spacing", dv_times[1] - dv_times[0], 80);
    end
    chk_near("b2b latency", dv_times.size() == 2 ? dv_times[1] - fall_cyc : -100, 9 * 8 + 3 + 3);

    // Reset during bit 4 of 0x5A
    clear_mon();
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rx8 = bits[i];
        repeat (8) @(negedge clk);
      end
      rx8 = bits[5];
      repeat (4) @(negedge clk);
    end
    chk("pre-reset active", 32'(act8), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst byte", 32'(byte8), 32'h00);
    chk("midrst dv", 32'(dv8), 32'h0);
    chk("midrst active", 32'(act8), 32'h0);
    chk("midrst ferr", 32'(ferr8), 32'h0);
    rx8 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    chk("post-rst dv count", 32'(dv_cnt), 32'd1);
    chk("post-rst byte", 32'(byte8), 32'h5A);

    // Break: line low for 20 bit times
    clear_mon();
    rx8 = 1'b0;
    repeat (160) @(negedge clk);
    rx8 = 1'b1;
    repeat (16) @(negedge clk);
    chk("break ferr count", 32'(ferr_cnt), 32'd1);
    chk("break dv count", 32'(dv_cnt), 32'd0);
    chk("break active end", 32'(act8), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    chk("after break dv", 32'(dv_cnt), 32'd1);
    chk("after break byte", 32'(byte8), 32'h81);
    chk("after break ferr", 32'(ferr_cnt), 32'd1);

    // 87 clocks per bit
    send_frame(8'h96, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    chk("cpb87 dv count", 32'(dv87_cnt), 32'd1);
    chk("cpb87 byte", 32'(dv87_byte), 32'h96);
    chk_near("cpb87 latency", dv87_cnt == 1 ? dv87_cyc - fall_cyc : -100, 9 * 87 + 43 + 3);
    chk("cpb87 ferr", 32'(ferr87), 32'h0);

    chk("strobe exclusivity", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
